cart_mem_fetch: RTL and testbench

//  Memory-side responder for the cartridge mappers (ASCII8/ASCII16/Konami...).

---
 rtl/cart_pkg.sv | 17 +
 rtl/cart_hit_buf.sv | 36 +++
 rtl/cart_mem_fetch.sv | 124 ++++++++++++
 tb/tb_cart_mem_fetch.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge memory fetch path.
package cart_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam logic [7:0] FfByte = 8'hFF;

  // Byte lane select within a 16-bit SDRAM word: hi=0 -> [7:0], hi=1 -> [15:8].
  function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/cart_hit_buf.sv
// Single-entry word buffer holding the last SDRAM fetch, with exact address compare.
module cart_hit_buf (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fill,
  input  logic        invalidate,
  input  logic [23:0] fill_addr,
  input  logic [15:0] fill_data,
  input  logic [23:0] lookup_addr,
  output logic        hit,
  output logic [15:0] data
);

  logic        valid_q;
  logic [23:0] addr_q;
  logic [15:0] data_q;

  // Invalidate has priority so a fill landing in the same cycle is discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (invalidate) begin
      valid_q <= 1'b0;
    end else if (fill) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr;
      data_q  <= fill_data;
    end
  end

  assign hit  = valid_q && (addr_q == lookup_addr);
  assign data = data_q;

endmodule

// File: rtl/cart_mem_fetch.sv
// Services mapped cartridge reads from a one-word hit buffer or an SDRAM word fetch,
// stretching the Z80 cycle with wait_n while the fetch is outstanding.
module cart_mem_fetch
  import cart_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        rd,
  input  logic [24:0] mem_addr,
  input  logic        invalidate,
  output logic [7:0]  d_to_cpu,
  output logic        wait_n,
  output logic        sdram_req,
  output logic [23:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic [15:0] sdram_dout,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  state_e           state_q, state_d;
  logic             acc, acc_q, start;
  logic [24:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       d_to_cpu_d;
  logic             wait_n_d, sdram_req_d, timeout_err_d;
  logic [23:0]      sdram_addr_d;
  logic             buf_hit, buf_fill;
  logic [15:0]      buf_data;

  assign acc      = cs && rd;
  assign start    = acc && !acc_q;
  assign buf_fill = (state_q == StReq) && sdram_ack;

  cart_hit_buf u_hit_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .fill        (buf_fill),
    .invalidate  (invalidate),
    .fill_addr   (addr_q[24:1]),
    .fill_data   (sdram_dout),
    .lookup_addr (mem_addr[24:1]),
    .hit         (buf_hit),
    .data        (buf_data)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    d_to_cpu_d    = d_to_cpu;
    wait_n_d      = wait_n;
    sdram_req_d   = sdram_req;
    sdram_addr_d  = sdram_addr;
    timeout_err_d = timeout_err;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (buf_hit) begin
            d_to_cpu_d = sel_byte(buf_data, mem_addr[0]);
          end else begin
            addr_d       = mem_addr;
            wait_n_d     = 1'b0;
            sdram_req_d  = 1'b1;
            sdram_addr_d = mem_addr[24:1];
            cnt_d        = '0;
            state_d      = StReq;
          end
        end
      end
      StReq: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        // Ack wins over a coincident timeout.
        if (sdram_ack) begin
          d_to_cpu_d  = sel_byte(sdram_dout, addr_q[0]);
          sdram_req_d = 1'b0;
          wait_n_d    = 1'b1;
          state_d     = StHold;
        end else if (cnt_q == CntLast) begin
          d_to_cpu_d    = FfByte;
          sdram_req_d   = 1'b0;
          timeout_err_d = 1'b1;
          wait_n_d      = 1'b1;
          state_d       = StHold;
        end
      end
      StHold: begin
        if (!acc) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      acc_q       <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      d_to_cpu    <= FfByte;
      wait_n      <= 1'b1;
      sdram_req   <= 1'b0;
      sdram_addr  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      d_to_cpu    <= d_to_cpu_d;
      wait_n      <= wait_n_d;
      sdram_req   <= sdram_req_d;
      sdram_addr  <= sdram_addr_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_cart_mem_fetch.sv
// Directed self-checking bench for cart_mem_fetch: miss, hit, timeout, invalidate, reset.
module tb_cart_mem_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs, rd, invalidate, sdram_ack;
  logic [24:0] mem_addr;
  logic [15:0] sdram_dout;
  logic [7:0]  d_to_cpu;
  logic        wait_n, sdram_req, timeout_err;
  logic [23:0] sdram_addr;

  int n_chk = 0;
  int n_err = 0;

  cart_mem_fetch #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cs          (cs),
    .rd          (rd),
    .mem_addr    (mem_addr),
    .invalidate  (invalidate),
    .d_to_cpu    (d_to_cpu),
    .wait_n      (wait_n),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .sdram_dout  (sdram_dout),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Holds cs&&rd until wait_n is seen high, counting low cycles.
  // ack_after>0 pulses sdram_ack so it is sampled on the edge ending the ack_after-th
  // wait cycle; inv raises invalidate in that same cycle.
  task automatic cpu_read(input logic [24:0] a, input int ack_after, input logic [15:0] w,
                          input logic inv, output int waits, output logic [7:0] data,
                          output logic saw_req);
    cs = 1'b1; rd = 1'b1; mem_addr = a;
    waits = 0; saw_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      sdram_ack  = 1'b0;
      invalidate = 1'b0;
      if (sdram_req) saw_req = 1'b1;
      if (wait_n) break;
      waits++;
      if (ack_after > 0 && waits == ack_after) begin
        sdram_ack  = 1'b1;
        sdram_dout = w;
        invalidate = inv;
      end
    end
    data = d_to_cpu;
    cs = 1'b0; rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  int         waits;
  logic [7:0] data;
  logic       saw_req;

  initial begin
    reset_n = 1'b0; cs = 1'b0; rd = 1'b0; invalidate = 1'b0;
    sdram_ack = 1'b0; mem_addr = '0; sdram_dout = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_wait_n", wait_n, 1'b1);
    check_eq("rst_req", sdram_req, 1'b0);
    check_eq("rst_addr", sdram_addr, 24'h0);
    check_eq("rst_data", d_to_cpu, 8'hFF);
    check_eq("rst_err", timeout_err, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Miss, ack after 5 wait cycles; odd address selects the high byte.
    cpu_read(25'h0012345, 5, 16'hBEEF, 1'b0, waits, data, saw_req);
    check_eq("miss_waits", waits, 5);
    check_eq("miss_req", saw_req, 1'b1);
    check_eq("miss_sdram_addr", sdram_addr, 24'h0091A2);
    check_eq("miss_data", data, 8'hBE);
    check_eq("miss_req_clr", sdram_req, 1'b0);

    // Both bytes of the buffered word hit with zero waits.
    cpu_read(25'h0012344, 0, 16'h0, 1'b0, waits, data, saw_req);
    check_eq("hit_lo_waits", waits, 0);
    check_eq("hit_lo_req", saw_req, 1'b0);
    check_eq("hit_lo_data", data, 8'hEF);
    cpu_read(25'h0012345, 0, 16'h0, 1'b0, waits, data, saw_req);
    check_eq("hit_hi_waits", waits, 0);
    check_eq("hit_hi_data", data, 8'hBE);

    // Timeout: no ack for 64 cycles.
    cpu_read(25'h0100000, 0, 16'h0, 1'b0, waits, data, saw_req);
    check_eq("to_waits", waits, 64);
    check_eq("to_req", saw_req, 1'b1);
    check_eq("to_data", data, 8'hFF);
    check_eq("to_err", timeout_err, 1'b1);
    sdram_ack = 1'b1; sdram_dout = 16'h1111;
    @(negedge clk);
    sdram_ack = 1'b0;
    @(negedge clk);
    check_eq("late_ack_err", timeout_err, 1'b1);
    check_eq("late_ack_wait", wait_n, 1'b1);
    cpu_read(25'h0012344, 0, 16'h0, 1'b0, waits, data, saw_req);
    check_eq("buf_kept_req", saw_req, 1'b0);
    check_eq("buf_kept_data", data, 8'hEF);

    // Invalidate forces a refetch of the same word.
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    cpu_read(25'h0012344, 2, 16'h1234, 1'b0, waits, data, saw_req);
    check_eq("inv_req", saw_req, 1'b1);
    check_eq("inv_waits", waits, 2);
    check_eq("inv_data", data, 8'h34);
    cpu_read(25'h0012345, 0, 16'h0, 1'b0, waits, data, saw_req);
    check_eq("refill_hit_req", saw_req, 1'b0);
    check_eq("refill_hit_data", data, 8'h12);

    // Ack and invalidate together: data delivered, buffer not filled.
    cpu_read(25'h0200003, 3, 16'hA55A, 1'b1, waits, data, saw_req);
    check_eq("ackinv_data", data, 8'hA5);
    check_eq("ackinv_err", timeout_err, 1'b1);
    cpu_read(25'h0200003, 1, 16'h7788, 1'b0, waits, data, saw_req);
    check_eq("ackinv_miss_req", saw_req, 1'b1);
    check_eq("ackinv_miss_data", data, 8'h77);

    // Async reset in the middle of a request.
    cs = 1'b1; rd = 1'b1; mem_addr = 25'h0300000;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_req", sdram_req, 1'b1);
    check_eq("mid_wait", wait_n, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_req", sdram_req, 1'b0);
    check_eq("arst_wait", wait_n, 1'b1);
    check_eq("arst_data", d_to_cpu, 8'hFF);
    check_eq("arst_err", timeout_err, 1'b0);
    cs = 1'b0; rd = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cpu_read(25'h0012345, 1, 16'hCAFE, 1'b0, waits, data, saw_req);
    check_eq("post_rst_req", saw_req, 1'b1);
    check_eq("post_rst_data", data, 8'hCA);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
